// File: rtl/alu_bit_serial_pkg.sv
// Shared opcode constants and state type for the bit-serial ALU and its 1-bit slice.
package alu_bit_serial_pkg;

    localparam logic [2:0] OpMov  = 3'b000;
    localparam logic [2:0] OpNot  = 3'b001;
    localparam logic [2:0] OpNand = 3'b011;
    localparam logic [2:0] OpNor  = 3'b100;
    localparam logic [2:0] OpAdd  = 3'b110;
    localparam logic [2:0] OpSub  = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OpAdd) || (op == OpSub);
    endfunction

endpackage

// File: rtl/alu_bit_serial_if.sv
// Request/response bundle of the bit-serial ALU.
interface alu_bit_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       select;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;

    modport master (
        output start, a, b, select,
        input  busy, done, result, c_out
    );

    modport slave (
        input  start, a, b, select,
        output busy, done, result, c_out
    );
endinterface

// File: rtl/alu_bit_serial_alu_1_bit.sv
// One-bit ALU slice: logic ops and full-adder carry chain for ADD/SUB.
module alu_bit_serial_alu_1_bit
    import alu_bit_serial_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [2:0] select,
    output logic       y,
    output logic       carry_out
);

    logic b_eff;

    always_comb begin
        y         = a;
        carry_out = 1'b0;
        b_eff     = b;
        case (select)
            OpNot:  y = ~a;
            OpNand: y = ~(a & b);
            OpNor:  y = ~(a | b);
            OpAdd, OpSub: begin
                // SUB inverts b; the +1 comes from the carry preloaded to 1.
                b_eff     = (select == OpSub) ? ~b : b;
                y         = a ^ b_eff ^ carry_in;
                carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
            end
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_bit_serial.sv
// Bit-serial ALU: processes one operand bit per RUN cycle, LSB first, through a single slice.
module alu_bit_serial
    import alu_bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    alu_bit_serial_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       sel_q;
    logic             carry_q;
    logic             c_out_q;
    logic [CntW-1:0]  cnt_q;

    logic accept;
    logic last_bit;
    logic slice_y;
    logic slice_carry;

    alu_bit_serial_alu_1_bit u_slice (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .carry_in  (carry_q),
        .select    (sel_q),
        .y         (slice_y),
        .carry_out (slice_carry)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_bit = (cnt_q == LastBit);
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end
            end
            StRun: begin
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= OpMov;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= bus.a;
                b_q      <= bus.b;
                sel_q    <= bus.select;
                carry_q  <= (bus.select == OpSub);
                cnt_q    <= '0;
                result_q <= '0;
                c_out_q  <= 1'b0;
            end else if (state_q == StRun) begin
                a_q      <= a_q >> 1;
                b_q      <= b_q >> 1;
                // Bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                result_q <= {slice_y, result_q[WIDTH-1:1]};
                carry_q  <= slice_carry;
                cnt_q    <= cnt_q + CntW'(1);
                if (last_bit) begin
                    c_out_q <= is_arith(sel_q) & slice_carry;
                end
            end
        end
    end

    assign bus.busy   = (state_q == StRun);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;

endmodule

// File: tb/tb_alu_bit_serial.sv
// Directed and randomized checks of alu_bit_serial against an arithmetic reference model.
module tb_alu_bit_serial;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    alu_bit_serial_if #(.WIDTH(W)) bus ();

    alu_bit_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {carry, result} computed directly from the opcode definitions.
    function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
        logic [W:0] s;
        case (op)
            3'b001:  s = {1'b0, ~x};
            3'b011:  s = {1'b0, ~(x & y)};
            3'b100:  s = {1'b0, ~(x | y)};
            3'b110:  s = {1'b0, x} + {1'b0, y};
            3'b101:  s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            default: s = {1'b0, x};
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation, scrambles the inputs during RUN and checks latency and outputs.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input string tag);
        logic [W:0] exp;
        logic [W-1:0] held;
        int k;
        exp = model(op, x, y);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = x;
        bus.b      = y;
        bus.select = op;
        @(negedge clk);
        bus.start  = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.a      = W'($urandom);
        bus.b      = W'($urandom);
        bus.select = 3'($urandom);
        k = 0;
        while (!bus.done && k < 3 * W) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        // done is registered by a consumer on the edge after it rises.
        check({tag, "_lat"}, 32'(k + 1), 32'(W + 1));
        check({tag, "_res"}, 32'(bus.result), 32'(exp[W-1:0]));
        check({tag, "_cout"}, 32'(bus.c_out), 32'(exp[W]));
        held = bus.result;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, 32'(bus.result), 32'(held));
    endtask

    initial begin
        logic [W:0]   exp;
        logic [W:0]   exps [3];
        logic [W-1:0] xs [3];
        logic [W-1:0] ys [3];
        logic [2:0]   ops [3];
        logic [W-1:0] got;
        int           t [3];
        int           k;
        int           pulses;

        // Reset, with start asserted to confirm reset wins.
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.a      = '0;
        bus.b      = '0;
        bus.select = 3'b110;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_cout", 32'(bus.c_out), 32'd0);
        bus.start = 1'b0;
        rst       = 1'b0;

        run_op(3'b110, 8'hFF, 8'h01, "add_ff_01");
        run_op(3'b101, 8'h07, 8'h05, "sub_7_5");
        run_op(3'b101, 8'h05, 8'h07, "sub_5_7");
        run_op(3'b011, 8'hF0, 8'hCC, "nand");
        run_op(3'b100, 8'hF0, 8'h0C, "nor");
        run_op(3'b001, 8'h5A, 8'h00, "not");
        run_op(3'b111, 8'h3C, 8'hFF, "mov111");
        run_op(3'b010, 8'hC3, 8'h11, "mov010");

        // start pulsed during RUN must be ignored.
        xs[0] = W'($urandom);
        ys[0] = W'($urandom);
        exp   = model(3'b110, xs[0], ys[0]);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = xs[0];
        bus.b      = ys[0];
        bus.select = 3'b110;
        @(negedge clk);
        bus.start  = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = ~xs[0];
        bus.b      = 8'h5A;
        bus.select = 3'b101;
        @(negedge clk);
        bus.start  = 1'b0;
        pulses = 0;
        got    = '0;
        repeat (W + 6) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                got = bus.result;
            end
        end
        check("busy_ign_pulses", 32'(pulses), 32'd1);
        check("busy_ign_res", 32'(got), 32'(exp[W-1:0]));
        check("busy_ign_cout", 32'(bus.c_out), 32'(exp[W]));

        // Reset while bit 4 is in the slice.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = 8'hAA;
        bus.b      = 8'h33;
        bus.select = 3'b110;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_cout", 32'(bus.c_out), 32'd0);
        pulses = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("midrst_nodone", 32'(pulses), 32'd0);
        run_op(3'b110, 8'h7F, 8'h01, "add_after_rst");

        // Continuous start with three operand sets.
        for (int i = 0; i < 3; i++) begin
            ops[i]  = (i == 1) ? 3'b101 : 3'b110;
            xs[i]   = W'($urandom);
            ys[i]   = W'($urandom);
            exps[i] = model(ops[i], xs[i], ys[i]);
        end
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = xs[0];
        bus.b      = ys[0];
        bus.select = ops[0];
        for (int i = 0; i < 3; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.busy && k < 4 * W);
            check("b2b_accept", 32'(bus.busy), 32'd1);
            if (i < 2) begin
                bus.a      = xs[i+1];
                bus.b      = ys[i+1];
                bus.select = ops[i+1];
            end else begin
                bus.start = 1'b0;
            end
            k = 0;
            while (!bus.done && k < 3 * W) begin
                @(negedge clk);
                k++;
            end
            t[i] = cyc;
            check("b2b_done", 32'(bus.done), 32'd1);
            check("b2b_res", 32'(bus.result), 32'(exps[i][W-1:0]));
            check("b2b_cout", 32'(bus.c_out), 32'(exps[i][W]));
        end
        check("b2b_gap01", 32'(t[1] - t[0]), 32'(W + 2));
        check("b2b_gap12", 32'(t[2] - t[1]), 32'(W + 2));

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
